// File: rtl/lab8_sysid_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
package lab8_sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StTsReq,
    StTsWait,
    StCheck,
    StFinish
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned SYSID_TIMER_W = 16;

endpackage

// File: rtl/lab8_sysid_timer.sv
// Per-attempt timeout counter: cleared at the start of each read attempt,
// counts while enabled, flags the last cycle of the attempt window.
module lab8_sysid_timer
  import lab8_sysid_pkg::*;
#(
  parameter logic [SYSID_TIMER_W-1:0] LIMIT = 16'd255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [SYSID_TIMER_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // An attempt lasts exactly LIMIT cycles: counts 0 .. LIMIT-1.
  assign expired = enable && (count_q == (LIMIT - 1'b1));

endmodule

// File: rtl/lab8_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp,
// compares them with the expected build and reports the result on status outputs.
module lab8_sysid_checker
  import lab8_sysid_pkg::*;
#(
  parameter logic [31:0]              EXPECTED_ID    = 32'd0,
  parameter logic [31:0]              EXPECTED_TS    = 32'd1489295197,
  parameter logic [SYSID_TIMER_W-1:0] TIMEOUT_CYCLES = 16'd255,
  parameter int unsigned              MAX_RETRIES    = 2,
  parameter bit                       AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] MaxRetries = 3'(MAX_RETRIES);

  sysid_state_t state_q, state_d;

  logic        auto_q;
  logic [2:0]  retry_q;
  logic        busy_q, done_q, pass_q, id_mm_q, ts_mm_q, timed_out_q;
  logic [31:0] id_value_q, ts_value_q;

  logic launch, timer_clr, timer_en, expired;
  logic retry_clr, retry_inc, cap_id, cap_ts, do_check, abort;
  logic is_ts, in_req, got_data;

  lab8_sysid_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clr),
    .enable (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    do_check  = 1'b0;
    abort     = 1'b0;
    launch    = (start || auto_q) && ((state_q == StIdle) || (state_q == StFinish));
    is_ts     = (state_q == StTsReq) || (state_q == StTsWait);
    in_req    = (state_q == StIdReq) || (state_q == StTsReq);
    // Data only counts on an accepting request cycle or while waiting for it.
    got_data  = m_readdatavalid && (!in_req || !m_waitrequest);
    timer_en  = (state_q == StIdReq) || (state_q == StIdWait) ||
                (state_q == StTsReq) || (state_q == StTsWait);
    unique case (state_q)
      StIdle, StFinish: begin
        if (launch) begin
          state_d   = StIdReq;
          timer_clr = 1'b1;
          retry_clr = 1'b1;
        end
      end
      StIdReq, StIdWait, StTsReq, StTsWait: begin
        if (got_data) begin
          if (is_ts) begin
            cap_ts  = 1'b1;
            state_d = StCheck;
          end else begin
            cap_id    = 1'b1;
            state_d   = StTsReq;
            timer_clr = 1'b1;
            retry_clr = 1'b1;
          end
        end else if (expired) begin
          if (retry_q < MaxRetries) begin
            retry_inc = 1'b1;
            timer_clr = 1'b1;
            state_d   = is_ts ? StTsReq : StIdReq;
          end else begin
            abort   = 1'b1;
            state_d = StFinish;
          end
        end else if (in_req && !m_waitrequest) begin
          state_d = is_ts ? StTsWait : StIdWait;
        end
      end
      StCheck: begin
        do_check = 1'b1;
        state_d  = StFinish;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_read    = 1'b0;
    m_address = SYSID_ADDR_ID;
    unique case (state_q)
      StIdReq:  m_read = 1'b1;
      StTsReq: begin
        m_read    = 1'b1;
        m_address = SYSID_ADDR_TS;
      end
      StTsWait: m_address = SYSID_ADDR_TS;
      default:  m_read = 1'b0;
    endcase
  end

  // busy/done are registered, so they follow the state by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_q      <= AUTO_START;
      retry_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      id_mm_q     <= 1'b0;
      ts_mm_q     <= 1'b0;
      timed_out_q <= 1'b0;
      id_value_q  <= '0;
      ts_value_q  <= '0;
    end else begin
      auto_q <= 1'b0;
      busy_q <= launch || !((state_q == StIdle) || (state_q == StFinish));
      done_q <= !launch && (state_q == StFinish);
      if (retry_clr) begin
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (launch) begin
        pass_q      <= 1'b0;
        id_mm_q     <= 1'b0;
        ts_mm_q     <= 1'b0;
        timed_out_q <= 1'b0;
        id_value_q  <= '0;
        ts_value_q  <= '0;
      end
      if (cap_id) id_value_q <= m_readdata;
      if (cap_ts) ts_value_q <= m_readdata;
      if (do_check) begin
        id_mm_q <= (id_value_q != EXPECTED_ID);
        ts_mm_q <= (ts_value_q != EXPECTED_TS);
        pass_q  <= (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
      end
      if (abort) begin
        timed_out_q <= 1'b1;
        pass_q      <= 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timed_out   = timed_out_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
